wb_stage: RTL and testbench

Write-back stage of the five-stage pipeline: the writer end of the register-file interface that the decode stage reads. It latches the MEM/WB pipeline register and extracts and sign- or zero-extends load data. It selects the write-back source and drives the register-file write port. It also keeps a 64-bit retired-instruction counter.

---
 rtl/wb_stage.sv | 121 ++++++++++++
 tb/tb_wb_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load extraction, write-back mux,
// register-file write port and the 64-bit retired-instruction counter.
module wb_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  mem_valid,
   input  logic                  mem_reg_write,
   input  logic [1:0]            mem_wb_sel,
   input  logic [2:0]            mem_funct3,
   input  logic [4:0]            mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_alu_result,
   input  logic [DATA_WIDTH-1:0] mem_pc_plus4,
   input  logic [DATA_WIDTH-1:0] mem_load_data,
   output logic                  wb_reg_write,
   output logic [4:0]            wb_rd_addr,
   output logic [DATA_WIDTH-1:0] wb_rd_data,
   output logic                  wb_load_misalign,
   output logic [63:0]           instret
);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic                  valid_p1;
   logic                  reg_write_p1;
   logic [1:0]            wb_sel_p1;
   logic [2:0]            funct3_p1;
   logic [4:0]            rd_addr_p1;
   logic [DATA_WIDTH-1:0] alu_result_p1;
   logic [DATA_WIDTH-1:0] pc_plus4_p1;
   logic [DATA_WIDTH-1:0] load_data_p1;
   logic [63:0]           instret_q;

   function automatic logic [DATA_WIDTH-1:0] extract_load(
      input logic [2:0]            funct3,
      input logic [1:0]            off,
      input logic [DATA_WIDTH-1:0] word
   );
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      byte_v = 8'(word >> {off, 3'b000});
      half_v = off[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   extract_load = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
         F3_LBU:  extract_load = {{(DATA_WIDTH-8){1'b0}}, byte_v};
         F3_LH:   extract_load = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
         F3_LHU:  extract_load = {{(DATA_WIDTH-16){1'b0}}, half_v};
         default: extract_load = word;
      endcase
   endfunction

   // Byte loads never misalign; unlisted funct3 codes are treated as LW.
   function automatic logic is_misaligned(
      input logic [2:0] funct3,
      input logic [1:0] off
   );
      case (funct3)
         F3_LB, F3_LBU: is_misaligned = 1'b0;
         F3_LH, F3_LHU: is_misaligned = off[0];
         default:       is_misaligned = (off != 2'b00);
      endcase
   endfunction

   // MEM -> WB boundary
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_p1      <= 1'b0;
         reg_write_p1  <= 1'b0;
         wb_sel_p1     <= 2'b00;
         funct3_p1     <= 3'b000;
         rd_addr_p1    <= 5'd0;
         alu_result_p1 <= '0;
         pc_plus4_p1   <= '0;
         load_data_p1  <= '0;
         instret_q     <= 64'd0;
      end else begin
         if (valid_p1 && !stall)
            instret_q <= instret_q + 64'd1;
         if (flush) begin
            valid_p1 <= 1'b0;
         end else if (!stall) begin
            valid_p1      <= mem_valid;
            reg_write_p1  <= mem_reg_write;
            wb_sel_p1     <= mem_wb_sel;
            funct3_p1     <= mem_funct3;
            rd_addr_p1    <= mem_rd_addr;
            alu_result_p1 <= mem_alu_result;
            pc_plus4_p1   <= mem_pc_plus4;
            load_data_p1  <= mem_load_data;
         end
      end
   end

   logic [DATA_WIDTH-1:0] load_value;

   always_comb begin
      load_value       = extract_load(funct3_p1, alu_result_p1[1:0], load_data_p1);
      wb_load_misalign = valid_p1 && (wb_sel_p1 == SEL_LOAD) &&
                         is_misaligned(funct3_p1, alu_result_p1[1:0]);
      case (wb_sel_p1)
         SEL_LOAD: wb_rd_data = load_value;
         SEL_LINK: wb_rd_data = pc_plus4_p1;
         default:  wb_rd_data = alu_result_p1;
      endcase
      wb_reg_write = valid_p1 && reg_write_p1 && (rd_addr_p1 != 5'd0) && !wb_load_misalign;
      wb_rd_addr   = rd_addr_p1;
   end

   assign instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the driver predicts each post-edge WB state
// from a record-level model; a monitor pops and compares after every edge.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush;
   logic        mem_valid, mem_reg_write;
   logic [1:0]  mem_wb_sel;
   logic [2:0]  mem_funct3;
   logic [4:0]  mem_rd_addr;
   logic [31:0] mem_alu_result, mem_pc_plus4, mem_load_data;
   logic        wb_reg_write;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_data;
   logic        wb_load_misalign;
   logic [63:0] instret;

   wb_stage #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
      .mem_rd_addr(mem_rd_addr), .mem_alu_result(mem_alu_result),
      .mem_pc_plus4(mem_pc_plus4), .mem_load_data(mem_load_data),
      .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
      .wb_rd_data(wb_rd_data), .wb_load_misalign(wb_load_misalign),
      .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        known;
      logic        rw;
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] alu, pc4, ld;
   } rec_t;

   typedef struct {
      logic        known;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        mis;
      logic [63:0] ir;
   } exp_t;

   rec_t        m;
   logic [63:0] m_instret;
   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic exp_t predict(input rec_t r, input logic [63:0] ir);
      exp_t        e;
      int          off;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] lv;
      logic        mis;
      off = int'(r.alu[1:0]);
      b   = 8'(r.ld >> (8 * off));
      h   = 16'(r.ld >> (16 * (off / 2)));
      case (r.f3)
         3'd0:    begin lv = int'($signed(b)); mis = 1'b0;          end
         3'd4:    begin lv = {24'd0, b};       mis = 1'b0;          end
         3'd1:    begin lv = int'($signed(h)); mis = (off % 2) != 0; end
         3'd5:    begin lv = {16'd0, h};       mis = (off % 2) != 0; end
         default: begin lv = r.ld;             mis = off != 0;       end
      endcase
      e.mis   = r.valid && (r.sel == 2'b01) && mis;
      e.data  = (r.sel == 2'b01) ? lv : (r.sel == 2'b10) ? r.pc4 : r.alu;
      e.we    = r.valid && r.rw && (r.rd != 0) && !e.mis;
      e.addr  = r.rd;
      e.known = r.known;
      e.ir    = ir;
      return e;
   endfunction

   function automatic void model_reset();
      m         = '{valid: 1'b0, known: 1'b1, rw: 1'b0, sel: 2'b00, f3: 3'b000,
                    rd: 5'd0, alu: 32'd0, pc4: 32'd0, ld: 32'd0};
      m_instret = 64'd0;
   endfunction

   // One clock of stimulus; the model advances exactly as the edge should.
   task automatic step(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] ld, input logic st, input logic fl);
      @(negedge clk);
      mem_valid = v; mem_reg_write = rw; mem_wb_sel = sel; mem_funct3 = f3;
      mem_rd_addr = rd; mem_alu_result = alu; mem_pc_plus4 = pc4;
      mem_load_data = ld; stall = st; flush = fl;
      if (m.valid && !st) m_instret = m_instret + 64'd1;
      if (fl) begin
         m.valid = 1'b0;
         m.known = 1'b0;
      end else if (!st) begin
         m = '{valid: v, known: 1'b1, rw: rw, sel: sel, f3: f3, rd: rd,
               alu: alu, pc4: pc4, ld: ld};
      end
      exp_q.push_back(predict(m, m_instret));
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic rand_step(input logic st, input logic fl);
      logic [2:0] f3s[6];
      logic [4:0] rd;
      f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step(1'($urandom), 1'($urandom), 2'($urandom), f3s[$urandom_range(0, 5)], rd,
           $urandom, $urandom, $urandom, st, fl);
   endtask

   // Monitor: the WB outputs are valid every cycle, so compare after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_reg_write", 64'(wb_reg_write), 64'(e.we));
            chk("sb_misalign", 64'(wb_load_misalign), 64'(e.mis));
            chk("sb_instret", instret, e.ir);
            if (e.known) begin
               chk("sb_rd_addr", 64'(wb_rd_addr), 64'(e.addr));
               chk("sb_rd_data", 64'(wb_rd_data), 64'(e.data));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] i0;
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      mem_valid = 1'b0; mem_reg_write = 1'b0; mem_wb_sel = 2'b00; mem_funct3 = 3'b000;
      mem_rd_addr = 5'd0; mem_alu_result = 32'd0; mem_pc_plus4 = 32'd0; mem_load_data = 32'd0;
      model_reset();
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;

      // ALU write-back and x0 suppression
      step(1, 1, 2'b00, 3'd0, 5'd5, 32'h1234_5678, 32'h4, 32'h0, 0, 0);
      after_edge();
      chk("alu_we", 64'(wb_reg_write), 64'd1);
      chk("alu_addr", 64'(wb_rd_addr), 64'd5);
      chk("alu_data", 64'(wb_rd_data), 64'h1234_5678);
      i0 = instret;
      step(1, 1, 2'b00, 3'd0, 5'd0, 32'hAAAA_5555, 32'h8, 32'h0, 0, 0);
      after_edge();
      chk("x0_we", 64'(wb_reg_write), 64'd0);
      step(0, 0, 2'b00, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0);
      after_edge();
      chk("x0_instret", instret, i0 + 64'd2);

      // Load extraction
      step(1, 1, 2'b01, 3'd0, 5'd7, 32'h0000_0100, 0, 32'h80F1_7F82, 0, 0);
      after_edge(); chk("lb_off0", 64'(wb_rd_data), 64'hFFFF_FF82);
      step(1, 1, 2'b01, 3'd4, 5'd7, 32'h0000_0101, 0, 32'h80F1_7F82, 0, 0);
      after_edge(); chk("lbu_off1", 64'(wb_rd_data), 64'h0000_007F);
      step(1, 1, 2'b01, 3'd1, 5'd7, 32'h0000_0102, 0, 32'h80F1_7F82, 0, 0);
      after_edge(); chk("lh_off2", 64'(wb_rd_data), 64'hFFFF_80F1);
      chk("lh_off2_mis", 64'(wb_load_misalign), 64'd0);
      chk("lh_off2_we", 64'(wb_reg_write), 64'd1);
      step(1, 1, 2'b01, 3'd5, 5'd7, 32'h0000_0102, 0, 32'h80F1_7F82, 0, 0);
      after_edge(); chk("lhu_off2", 64'(wb_rd_data), 64'h0000_80F1);
      step(1, 1, 2'b01, 3'd2, 5'd7, 32'h0000_0100, 0, 32'h80F1_7F82, 0, 0);
      after_edge(); chk("lw_off0", 64'(wb_rd_data), 64'h80F1_7F82);

      // Misaligned loads
      step(1, 1, 2'b01, 3'd2, 5'd9, 32'h0000_1002, 0, 32'h1111_2222, 0, 0);
      after_edge();
      chk("lw_mis_flag", 64'(wb_load_misalign), 64'd1);
      chk("lw_mis_we", 64'(wb_reg_write), 64'd0);
      step(1, 1, 2'b01, 3'd1, 5'd9, 32'h0000_1001, 0, 32'h1111_2222, 0, 0);
      after_edge();
      chk("lh_mis_flag", 64'(wb_load_misalign), 64'd1);
      chk("lh_mis_we", 64'(wb_reg_write), 64'd0);

      // Stall holds a JAL; release counts it; flush+stall yields a bubble
      step(1, 1, 2'b10, 3'd0, 5'd1, 32'h0000_0040, 32'h0000_0104, 32'h0, 0, 0);
      after_edge();
      i0 = instret;
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 2'b00, 3'd0, 5'(k + 10), $urandom, $urandom, $urandom, 1, 0);
         after_edge();
         chk("stall_data", 64'(wb_rd_data), 64'h0000_0104);
         chk("stall_instret", instret, i0);
      end
      step(1, 1, 2'b00, 3'd0, 5'd3, 32'h0000_0077, 32'h0, 32'h0, 0, 0);
      after_edge();
      chk("release_instret", instret, i0 + 64'd1);
      step(1, 1, 2'b00, 3'd0, 5'd4, 32'h0000_0099, 32'h0, 32'h0, 1, 1);
      after_edge();
      chk("flush_stall_we", 64'(wb_reg_write), 64'd0);

      // Reset asserted mid-stall discards the held instruction
      step(1, 1, 2'b00, 3'd0, 5'd6, 32'hDEAD_BEEF, 32'h1, 32'h2, 0, 0);
      step(1, 1, 2'b01, 3'd1, 5'd8, 32'h0000_1003, 32'h3, 32'h4, 1, 0);
      after_edge();
      #1 rst = 1'b0;
      #1;
      chk("rst_we", 64'(wb_reg_write), 64'd0);
      chk("rst_addr", 64'(wb_rd_addr), 64'd0);
      chk("rst_data", 64'(wb_rd_data), 64'd0);
      chk("rst_mis", 64'(wb_load_misalign), 64'd0);
      chk("rst_instret", instret, 64'd0);
      model_reset();
      @(negedge clk);
      #2 rst = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 400; n++)
         rand_step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);

      // instret wrap
      step(0, 0, 2'b00, 3'd0, 5'd0, 0, 0, 0, 0, 1);
      after_edge();
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.instret_q;
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      step(1, 1, 2'b00, 3'd0, 5'd2, 32'h5, 32'h0, 32'h0, 0, 0);
      step(0, 0, 2'b00, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0);
      after_edge();
      chk("instret_wrap", instret, 64'd0);

      repeat (2) @(negedge clk);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
